// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for truth-table sweeper engines and their benches.
package truth_table_sweeper_pkg;

    // Sweep FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Default expected table: implication r = x | ~y with vector = {x,y}
    localparam logic [3:0] TT_IMPLICATION = 4'b1101;

    localparam int unsigned DEF_N_IN   = 2;
    localparam int unsigned DEF_SETTLE = 1;

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Stimulus/response and result bus between a sweeper and its user/function under test.
interface truth_table_sweeper_if #(
    parameter int unsigned N_IN = 2
);
    logic                     start;
    logic                     dut_r;
    logic [N_IN-1:0]          vec_out;
    logic                     busy;
    logic                     done;
    logic                     pass;
    logic [(1<<N_IN)-1:0]     captured;
    logic [N_IN:0]            err_cnt;
    logic [N_IN-1:0]          first_fail_idx;
    logic                     first_fail_valid;

    // Sweeper side
    modport master (
        input  start, dut_r,
        output vec_out, busy, done, pass, captured, err_cnt,
               first_fail_idx, first_fail_valid
    );

    // Requester / function-under-test side
    modport slave (
        output start, dut_r,
        input  vec_out, busy, done, pass, captured, err_cnt,
               first_fail_idx, first_fail_valid
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Drives every input vector onto a function under test, samples its response
// after SETTLE cycles, and compares the captured table against EXPECT.
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int unsigned          N_IN   = DEF_N_IN,
    parameter int unsigned          SETTLE = DEF_SETTLE,
    parameter logic [(1<<N_IN)-1:0] EXPECT = TT_IMPLICATION
) (
    input  logic                  clk,
    input  logic                  rst_n,
    truth_table_sweeper_if.master bus
);

    localparam int unsigned N_VEC = 1 << N_IN;
    localparam int unsigned ERR_W = N_IN + 1;
    localparam int unsigned SC_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(N_VEC - 1);
    localparam logic [SC_W-1:0] SC_LAST  = SC_W'(SETTLE - 1);

    state_t             r_state;
    state_t             w_state_next;

    logic [N_IN-1:0]    r_idx;
    logic [SC_W-1:0]    r_sc;
    logic [N_IN-1:0]    r_vec_out;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [N_VEC-1:0]   r_captured;
    logic [ERR_W-1:0]   r_err_cnt;
    logic [N_IN-1:0]    r_ffi;
    logic               r_ffv;

    logic [N_IN-1:0]    w_idx_next;
    logic [SC_W-1:0]    w_sc_next;
    logic [N_IN-1:0]    w_vec_out_next;
    logic               w_busy_next;
    logic               w_done_next;
    logic               w_pass_next;
    logic [N_VEC-1:0]   w_captured_next;
    logic [ERR_W-1:0]   w_err_next;
    logic [N_IN-1:0]    w_ffi_next;
    logic               w_ffv_next;
    logic               w_mismatch;

    assign w_mismatch = (bus.dut_r != EXPECT[r_idx]);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: start accepted only when not sweeping; last vector ends the sweep
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) w_state_next = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (r_sc == SC_LAST) w_state_next = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (r_idx == LAST_IDX) w_state_next = ST_DONE;
                else                   w_state_next = ST_DRIVE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Output/datapath next values: counters, capture, compare and status flags
    always_comb begin
        w_idx_next      = r_idx;
        w_sc_next       = r_sc;
        w_captured_next = r_captured;
        w_err_next      = r_err_cnt;
        w_ffi_next      = r_ffi;
        w_ffv_next      = r_ffv;
        w_pass_next     = r_pass;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    w_idx_next      = '0;
                    w_sc_next       = '0;
                    w_captured_next = '0;
                    w_err_next      = '0;
                    w_ffi_next      = '0;
                    w_ffv_next      = 1'b0;
                    w_pass_next     = 1'b0;
                end
            end
            ST_DRIVE: begin
                w_sc_next = r_sc + SC_W'(1);
            end
            ST_SAMPLE: begin
                w_captured_next[r_idx] = bus.dut_r;
                if (w_mismatch) begin
                    w_err_next = r_err_cnt + ERR_W'(1);
                    if (!r_ffv) begin
                        w_ffi_next = r_idx;
                        w_ffv_next = 1'b1;
                    end
                end
                if (r_idx == LAST_IDX) begin
                    w_pass_next = (w_err_next == ERR_W'(0));
                end else begin
                    w_idx_next = r_idx + N_IN'(1);
                    w_sc_next  = '0;
                end
            end
            default: ;
        endcase

        w_busy_next    = (w_state_next == ST_DRIVE) || (w_state_next == ST_SAMPLE);
        w_done_next    = (w_state_next == ST_DONE);
        w_vec_out_next = w_busy_next ? w_idx_next : '0;
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_sc       <= '0;
            r_vec_out  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_captured <= '0;
            r_err_cnt  <= '0;
            r_ffi      <= '0;
            r_ffv      <= 1'b0;
        end else begin
            r_idx      <= w_idx_next;
            r_sc       <= w_sc_next;
            r_vec_out  <= w_vec_out_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
            r_pass     <= w_pass_next;
            r_captured <= w_captured_next;
            r_err_cnt  <= w_err_next;
            r_ffi      <= w_ffi_next;
            r_ffv      <= w_ffv_next;
        end
    end

    assign bus.vec_out          = r_vec_out;
    assign bus.busy             = r_busy;
    assign bus.done             = r_done;
    assign bus.pass             = r_pass;
    assign bus.captured         = r_captured;
    assign bus.err_cnt          = r_err_cnt;
    assign bus.first_fail_idx   = r_ffi;
    assign bus.first_fail_valid = r_ffv;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper with a result scoreboard.
module tb_truth_table_sweeper;
    import truth_table_sweeper_pkg::*;

    typedef struct {
        logic [3:0] cap;
        logic [2:0] err;
        logic [1:0] ffi;
        logic       ffv;
        logic       pass;
    } exp_t;

    localparam int MODE_IMPL = 0;
    localparam int MODE_ZERO = 1;
    localparam int MODE_AND  = 2;

    logic clk;
    logic rst_n;
    int   mode;
    logic glitch;
    int   n_checks;
    int   n_errors;
    exp_t q0[$];
    exp_t q1[$];

    truth_table_sweeper_if #(.N_IN(2)) if0 ();
    truth_table_sweeper_if #(.N_IN(2)) if1 ();

    truth_table_sweeper #(.N_IN(2), .SETTLE(1), .EXPECT(4'b1101)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    truth_table_sweeper #(.N_IN(2), .SETTLE(3), .EXPECT(4'b1101)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    // Function under test: vec = {x,y}
    function automatic logic fut(input int m, input logic [1:0] v);
        logic x;
        logic y;
        x = v[1];
        y = v[0];
        case (m)
            MODE_IMPL: return x | ~y;
            MODE_ZERO: return 1'b0;
            default:   return x & y;
        endcase
    endfunction

    assign if0.dut_r = fut(mode, if0.vec_out);
    assign if1.dut_r = fut(MODE_IMPL, if1.vec_out) ^ glitch;

    // Reference result of a full sweep of function m against an expected table
    function automatic exp_t model(input int m, input logic [3:0] expect_tt);
        exp_t e;
        logic [1:0] v;
        e.cap = '0; e.err = '0; e.ffi = '0; e.ffv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            v = 2'(i);
            e.cap[i] = fut(m, v);
            if (e.cap[i] != expect_tt[i]) begin
                e.err = e.err + 3'd1;
                if (!e.ffv) begin
                    e.ffi = v;
                    e.ffv = 1'b1;
                end
            end
        end
        e.pass = (e.err == 3'd0);
        return e;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset0(input string tag);
        check({tag, "_vec"},  32'(if0.vec_out), 0);
        check({tag, "_busy"}, 32'(if0.busy), 0);
        check({tag, "_done"}, 32'(if0.done), 0);
        check({tag, "_pass"}, 32'(if0.pass), 0);
        check({tag, "_cap"},  32'(if0.captured), 0);
        check({tag, "_err"},  32'(if0.err_cnt), 0);
        check({tag, "_ffi"},  32'(if0.first_fail_idx), 0);
        check({tag, "_ffv"},  32'(if0.first_fail_valid), 0);
    endtask

    task automatic pop_check0(input string tag);
        exp_t e;
        check({tag, "_sb_depth"}, 32'(q0.size() != 0), 1);
        if (q0.size() != 0) begin
            e = q0.pop_front();
            check({tag, "_cap"},  32'(if0.captured), 32'(e.cap));
            check({tag, "_err"},  32'(if0.err_cnt), 32'(e.err));
            check({tag, "_ffi"},  32'(if0.first_fail_idx), 32'(e.ffi));
            check({tag, "_ffv"},  32'(if0.first_fail_valid), 32'(e.ffv));
            check({tag, "_pass"}, 32'(if0.pass), 32'(e.pass));
            check({tag, "_busy"}, 32'(if0.busy), 0);
            check({tag, "_vec"},  32'(if0.vec_out), 0);
        end
    endtask

    // Waits for done after the accepted-start edge; returns edges elapsed
    task automatic wait_done0(output int n);
        n = 0;
        while (!if0.done && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic sweep0(input string tag);
        int n;
        if0.start = 1'b1;
        q0.push_back(model(mode, TT_IMPLICATION));
        tick();
        if0.start = 1'b0;
        wait_done0(n);
        check({tag, "_latency"}, 32'(n), 8);
        pop_check0(tag);
    endtask

    initial begin
        int   n;
        exp_t e;
        n_checks  = 0;
        n_errors  = 0;
        mode      = MODE_IMPL;
        glitch    = 1'b0;
        rst_n     = 1'b0;
        if0.start = 1'b0;
        if1.start = 1'b0;
        #2;
        check_reset0("reset");
        check("reset_dut3_done", 32'(if1.done), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Correct implication cell: step through vectors, then results
        mode = MODE_IMPL;
        if0.start = 1'b1;
        q0.push_back(model(mode, TT_IMPLICATION));
        tick();
        if0.start = 1'b0;
        for (int e_i = 0; e_i < 8; e_i++) begin
            check($sformatf("impl_vec_e%0d", e_i), 32'(if0.vec_out), 32'(e_i / 2));
            check($sformatf("impl_busy_e%0d", e_i), 32'(if0.busy), 1);
            check($sformatf("impl_done_e%0d", e_i), 32'(if0.done), 0);
            tick();
        end
        check("impl_done_e8", 32'(if0.done), 1);
        pop_check0("impl");

        // Response tied low
        mode = MODE_ZERO;
        sweep0("zero");

        // AND cell instead of implication
        mode = MODE_AND;
        sweep0("and");

        // Start held through the sweep, then a restart from DONE
        mode = MODE_IMPL;
        if0.start = 1'b1;
        q0.push_back(model(mode, TT_IMPLICATION));
        tick();
        wait_done0(n);
        check("hold_latency", 32'(n), 8);
        pop_check0("hold");
        q0.push_back(model(mode, TT_IMPLICATION));
        tick();
        check("restart_done", 32'(if0.done), 0);
        check("restart_busy", 32'(if0.busy), 1);
        check("restart_cap",  32'(if0.captured), 0);
        check("restart_err",  32'(if0.err_cnt), 0);
        check("restart_pass", 32'(if0.pass), 0);
        if0.start = 1'b0;
        wait_done0(n);
        check("restart_latency", 32'(n), 8);
        pop_check0("restart");

        // Asynchronous reset mid-sweep
        mode = MODE_ZERO;
        if0.start = 1'b1;
        q0.push_back(model(mode, TT_IMPLICATION));
        tick();
        if0.start = 1'b0;
        tick();
        tick();
        tick();
        check("pre_rst_busy", 32'(if0.busy), 1);
        rst_n = 1'b0;
        q0.delete();
        #1;
        check_reset0("midrst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        check("post_rst_busy", 32'(if0.busy), 0);
        check("post_rst_done", 32'(if0.done), 0);
        mode = MODE_IMPL;
        sweep0("post_rst");

        // SETTLE=3 with a glitch in the first DRIVE cycle of each vector
        if1.start = 1'b1;
        q1.push_back(model(MODE_IMPL, TT_IMPLICATION));
        tick();
        if1.start = 1'b0;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("s3_vec_k%0d", k), 32'(if1.vec_out), 32'(k));
            glitch = 1'b1;
            tick();
            n++;
            glitch = 1'b0;
            for (int j = 0; j < 3; j++) begin
                if (n < 15) check($sformatf("s3_vec_hold_n%0d", n), 32'(if1.vec_out), 32'(k));
                tick();
                n++;
                check($sformatf("s3_done_n%0d", n), 32'(if1.done), 32'(n == 16));
            end
        end
        check("s3_sb_depth", 32'(q1.size() != 0), 1);
        if (q1.size() != 0) begin
            e = q1.pop_front();
            check("s3_cap",  32'(if1.captured), 32'(e.cap));
            check("s3_err",  32'(if1.err_cnt), 32'(e.err));
            check("s3_ffv",  32'(if1.first_fail_valid), 32'(e.ffv));
            check("s3_pass", 32'(if1.pass), 32'(e.pass));
            check("s3_busy", 32'(if1.busy), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
